// File: rtl/iob_mem_merge2_pkg.sv
// Shared definitions for the two-master IOb memory merge: FSM encoding and
// the IOb request/response field layout helpers.
package iob_mem_merge2_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // IOb request vector, LSB first: wstrb | wdata | address | avalid
    function automatic int req_w(input int aw, input int dw);
        return 1 + aw + dw + (dw / 8);
    endfunction

    // IOb response vector: rdata | rvalid | ready
    function automatic int resp_w(input int dw);
        return dw + 2;
    endfunction

    function automatic int wstrb_off();
        return 0;
    endfunction

    function automatic int wdata_off(input int dw);
        return dw / 8;
    endfunction

    function automatic int addr_off(input int dw);
        return dw + (dw / 8);
    endfunction

    function automatic int avalid_off(input int aw, input int dw);
        return aw + dw + (dw / 8);
    endfunction

endpackage

// File: rtl/iob_mem_merge2_rr_arb2.sv
// Two-way round-robin arbiter. A grant that is presented but not yet
// acknowledged is locked so the requester seen downstream cannot change
// until the transfer completes.
module iob_rr_arb2 (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       cke,
    input  logic [1:0] req,
    input  logic       ack,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    logic last_r;
    logic lock_r;
    logic lock_idx_r;

    // Grant selection: locked winner first, else single requester, else the one not served last
    always_comb begin
        gnt_idx = 1'b0;
        gnt_vld = 1'b0;
        if (lock_r) begin
            gnt_idx = lock_idx_r;
            gnt_vld = req[lock_idx_r];
        end else begin
            case (req)
                2'b01: begin
                    gnt_idx = 1'b0;
                    gnt_vld = 1'b1;
                end
                2'b10: begin
                    gnt_idx = 1'b1;
                    gnt_vld = 1'b1;
                end
                2'b11: begin
                    gnt_idx = ~last_r;
                    gnt_vld = 1'b1;
                end
                default: begin
                    gnt_idx = 1'b0;
                    gnt_vld = 1'b0;
                end
            endcase
        end
    end

    // Round-robin history and grant lock; last_r resets to 1 so master 0 wins first contention
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_r     <= 1'b1;
            lock_r     <= 1'b0;
            lock_idx_r <= 1'b0;
        end else if (cke) begin
            if (gnt_vld && ack) begin
                last_r <= gnt_idx;
                lock_r <= 1'b0;
            end else if (gnt_vld) begin
                lock_r     <= 1'b1;
                lock_idx_r <= gnt_idx;
            end else begin
                lock_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iob_mem_merge2.sv
// Merges the instruction (m0) and data (m1) IOb buses onto one memory port.
// Round-robin arbitration, at most one outstanding read, read data routed
// back to the master that issued the read.
module iob_mem_merge2
    import iob_mem_merge2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                m0_avalid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_rvalid_o,
    output logic                m0_ready_o,
    input  logic                m1_avalid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_rvalid_o,
    output logic                m1_ready_o,
    output logic                s_avalid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_rvalid_i,
    input  logic                s_ready_i
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int REQ_W    = req_w(ADDR_W, DATA_W);
    localparam int AV_OFF   = avalid_off(ADDR_W, DATA_W);
    localparam int ADDR_OFF = addr_off(DATA_W);
    localparam int WD_OFF   = wdata_off(DATA_W);
    localparam int WS_OFF   = wstrb_off();

    logic [REQ_W-1:0] m0_req;
    logic [REQ_W-1:0] m1_req;
    logic [REQ_W-1:0] sel_req;
    logic [1:0]       arb_req;
    logic             gnt_idx;
    logic             gnt_vld;
    logic             idle;
    logic             core_valid;
    logic             core_xfer;
    logic             is_rd;
    state_t           state_r;
    state_t           state_nxt;
    logic             owner_r;
    logic             owner_nxt;
    logic             stray_err_r;

    assign m0_req = {m0_avalid_i, m0_addr_i, m0_wdata_i, m0_wstrb_i};
    assign m1_req = {m1_avalid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i};
    assign idle   = (state_r == IDLE);

    // Requests only compete while no read is outstanding and the clock is enabled
    assign arb_req = {m1_avalid_i, m0_avalid_i} & {2{idle & cke_i}};

    iob_rr_arb2 u_arb (
        .clk     (clk_i),
        .arst_n  (arst_i),
        .cke     (cke_i),
        .req     (arb_req),
        .ack     (s_ready_i),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Granted request goes straight to the slave with no added latency
    assign sel_req    = gnt_idx ? m1_req : m0_req;
    assign core_valid = gnt_vld & sel_req[AV_OFF];
    assign core_xfer  = core_valid & s_ready_i;
    assign s_addr_o   = sel_req[ADDR_OFF +: ADDR_W];
    assign s_wdata_o  = sel_req[WD_OFF +: DATA_W];
    assign s_wstrb_o  = sel_req[WS_OFF +: STRB_W];
    assign is_rd      = (s_wstrb_o == {STRB_W{1'b0}});

    // Handshake outputs are forced low while reset is asserted
    assign s_avalid_o = core_valid & arst_i;
    assign m0_ready_o = core_xfer & ~gnt_idx & arst_i;
    assign m1_ready_o = core_xfer &  gnt_idx & arst_i;

    // Read data is broadcast; only the read owner sees rvalid
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign m0_rvalid_o = s_rvalid_i & cke_i & (state_r == RD_WAIT) & ~owner_r;
    assign m1_rvalid_o = s_rvalid_i & cke_i & (state_r == RD_WAIT) &  owner_r;

    // Next-state: an accepted read waits for its single response, writes stay in IDLE
    always_comb begin
        state_nxt = state_r;
        owner_nxt = owner_r;
        case (state_r)
            IDLE: begin
                if (core_xfer && is_rd) begin
                    state_nxt = RD_WAIT;
                    owner_nxt = gnt_idx;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (s_rvalid_i) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RD_WAIT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, read owner and sticky stray-response flag
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            stray_err_r <= 1'b0;
        end else if (cke_i) begin
            state_r <= state_nxt;
            owner_r <= owner_nxt;
            if (idle && s_rvalid_i) begin
                stray_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_mem_merge2.sv
// Self-checking bench for iob_mem_merge2: directed cycle table followed by
// randomized traffic checked against a transaction-level reference model.
module tb_iob_mem_merge2;

    logic        clk_i = 1'b0;
    logic        arst_i, cke_i;
    logic        m0_avalid_i, m1_avalid_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]  m0_wstrb_i, m1_wstrb_i;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_rvalid_o, m0_ready_o, m1_rvalid_o, m1_ready_o;
    logic        s_avalid_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic [31:0] s_rdata_i;
    logic        s_rvalid_i, s_ready_i;

    int total = 0;
    int bad   = 0;

    iob_mem_merge2 #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
        .m0_avalid_i(m0_avalid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
        .m0_rdata_o(m0_rdata_o), .m0_rvalid_o(m0_rvalid_o), .m0_ready_o(m0_ready_o),
        .m1_avalid_i(m1_avalid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
        .m1_rdata_o(m1_rdata_o), .m1_rvalid_o(m1_rvalid_o), .m1_ready_o(m1_ready_o),
        .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
        .s_rdata_i(s_rdata_i), .s_rvalid_i(s_rvalid_i), .s_ready_i(s_ready_i)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    localparam logic [31:0] WD0 = 32'h5A5A5A5A;
    localparam logic [31:0] WD1 = 32'hA5A5A5A5;

    typedef struct {
        logic        rst;
        logic        a0;  logic [3:0] s0;  logic [31:0] ad0;
        logic        a1;  logic [3:0] s1;  logic [31:0] ad1;
        logic        rdy; logic        rv; logic [31:0] rd;
        logic        e_sav; logic e_sel; logic [31:0] e_saddr;
        logic        e_r0; logic e_r1; logic e_v0; logic e_v1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst,
                                input logic a0, input logic [3:0] s0, input logic [31:0] ad0,
                                input logic a1, input logic [3:0] s1, input logic [31:0] ad1,
                                input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic e_sav, input logic e_sel, input logic [31:0] e_saddr,
                                input logic e_r0, input logic e_r1, input logic e_v0, input logic e_v1);
        vec_t v;
        v.rst = rst; v.a0 = a0; v.s0 = s0; v.ad0 = ad0; v.a1 = a1; v.s1 = s1; v.ad1 = ad1;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.e_sav = e_sav; v.e_sel = e_sel; v.e_saddr = e_saddr;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_v0 = e_v0; v.e_v1 = e_v1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    // Random-phase master requests and reference model state
    logic        av[2];
    logic [31:0] ad[2], wd[2];
    logic [3:0]  st[2];
    int          last_m, held, owner, rd_wait, win;
    bit          busy;
    logic [31:0] rd_addr;

    task automatic drive_masters();
        m0_avalid_i = av[0]; m0_addr_i = ad[0]; m0_wdata_i = wd[0]; m0_wstrb_i = st[0];
        m1_avalid_i = av[1]; m1_addr_i = ad[1]; m1_wdata_i = wd[1]; m1_wstrb_i = st[1];
    endtask

    task automatic idle_inputs();
        av[0] = 1'b0; av[1] = 1'b0;
        ad[0] = 32'h0; ad[1] = 32'h0; wd[0] = WD0; wd[1] = WD1; st[0] = 4'h0; st[1] = 4'h0;
        drive_masters();
        s_rdata_i = 32'h0; s_rvalid_i = 1'b0; s_ready_i = 1'b0;
    endtask

    initial begin
        cke_i  = 1'b1;
        arst_i = 1'b0;
        idle_inputs();
        // Reset state, with a master requesting and the slave ready
        av[0] = 1'b1; ad[0] = 32'h40; drive_masters(); s_ready_i = 1'b1; s_rvalid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst s_avalid", 32'(s_avalid_o), 32'h0);
        chk("rst m0_ready", 32'(m0_ready_o), 32'h0);
        chk("rst m1_ready", 32'(m1_ready_o), 32'h0);
        chk("rst m0_rvalid", 32'(m0_rvalid_o), 32'h0);
        chk("rst m1_rvalid", 32'(m1_rvalid_o), 32'h0);
        idle_inputs();
        @(posedge clk_i); #1 arst_i = 1'b1;

        // Directed cycle table: rst a0 s0 ad0 a1 s1 ad1 rdy rv rd | sav sel saddr r0 r1 v0 v1
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        // single read from m0
        tbl.push_back(mk(0,1,4'h0,32'h100,0,0,32'h0,  1,0,32'h0,        1,0,32'h100,1,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,1,32'hDEADBEEF, 0,0,32'h0,  0,0,1,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        // contention after reset
        tbl.push_back(mk(1,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,1,4'h0,32'h200,1,0,32'h300,1,0,32'h0,        1,0,32'h200,1,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  1,0,32'h300,1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  1,0,32'h300,1,1,32'h11111111, 0,0,32'h0,  0,0,1,0));
        tbl.push_back(mk(0,1,4'h0,32'h204,1,0,32'h300,1,0,32'h0,        1,1,32'h300,0,1,0,0));
        tbl.push_back(mk(0,1,4'h0,32'h204,0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,1,4'h0,32'h204,0,0,32'h0,  1,1,32'h22222222, 0,0,32'h0,  0,0,0,1));
        tbl.push_back(mk(0,1,4'h0,32'h204,0,0,32'h0,  1,0,32'h0,        1,0,32'h204,1,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,1,32'h33333333, 0,0,32'h0,  0,0,1,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        // back-to-back writes from m1
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,0,4'h0,32'h0,1,4'hF,32'h4,1,0,32'h0,     1,1,32'h4,  0,1,0,0));
        tbl.push_back(mk(0,1,4'h3,32'h8,  0,0,32'h0,  1,0,32'h0,        1,0,32'h8,  1,0,0,0));
        // slave stall: m0 locked, m1 arrives later
        tbl.push_back(mk(0,1,4'h0,32'h500,0,0,32'h0,  0,0,32'h0,        1,0,32'h500,0,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,1,4'h0,32'h500,1,4'hF,32'h600,0,0,32'h0, 1,0,32'h500,0,0,0,0));
        tbl.push_back(mk(0,1,4'h0,32'h500,1,4'hF,32'h600,1,0,32'h0,     1,0,32'h500,1,0,0,0));
        // read blocking m1 write
        tbl.push_back(mk(0,0,4'h0,32'h0,  1,4'hF,32'h600,1,0,32'h0,     0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  1,4'hF,32'h600,1,1,32'h44444444,0,0,32'h0,0,0,1,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  1,4'hF,32'h600,1,0,32'h0,     1,1,32'h600,0,1,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        // stray response in IDLE
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,1,32'h0BADF00D, 0,0,32'h0,  0,0,0,0));
        // reset during a read, late response ignored, fresh read completes
        tbl.push_back(mk(0,0,4'h0,32'h0,  1,0,32'h700,1,0,32'h0,        1,1,32'h700,0,1,0,0));
        tbl.push_back(mk(1,1,4'h0,32'h900,0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,1,32'hCAFEF00D, 0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  1,0,32'h710,1,0,32'h0,        1,1,32'h710,0,1,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,1,32'h55555555, 0,0,32'h0,  0,0,0,1));
        tbl.push_back(mk(0,0,4'h0,32'h0,  0,0,32'h0,  1,0,32'h0,        0,0,32'h0,  0,0,0,0));

        foreach (tbl[i]) begin
            @(posedge clk_i); #1;
            arst_i = ~tbl[i].rst;
            av[0] = tbl[i].a0; st[0] = tbl[i].s0; ad[0] = tbl[i].ad0;
            av[1] = tbl[i].a1; st[1] = tbl[i].s1; ad[1] = tbl[i].ad1;
            drive_masters();
            s_ready_i = tbl[i].rdy; s_rvalid_i = tbl[i].rv; s_rdata_i = tbl[i].rd;
            @(negedge clk_i);
            chk($sformatf("v%0d s_avalid", i), 32'(s_avalid_o), 32'(tbl[i].e_sav));
            if (tbl[i].e_sav) begin
                chk($sformatf("v%0d s_addr", i), s_addr_o, tbl[i].e_saddr);
                chk($sformatf("v%0d s_wdata", i), s_wdata_o, tbl[i].e_sel ? WD1 : WD0);
                chk($sformatf("v%0d s_wstrb", i), 32'(s_wstrb_o), 32'(tbl[i].e_sel ? tbl[i].s1 : tbl[i].s0));
            end
            chk($sformatf("v%0d m0_ready", i), 32'(m0_ready_o), 32'(tbl[i].e_r0));
            chk($sformatf("v%0d m1_ready", i), 32'(m1_ready_o), 32'(tbl[i].e_r1));
            chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid_o), 32'(tbl[i].e_v0));
            chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid_o), 32'(tbl[i].e_v1));
            if (tbl[i].e_v0) chk($sformatf("v%0d m0_rdata", i), m0_rdata_o, tbl[i].rd);
            if (tbl[i].e_v1) chk($sformatf("v%0d m1_rdata", i), m1_rdata_o, tbl[i].rd);
        end

        // Randomized traffic from a clean reset
        @(posedge clk_i); #1;
        arst_i = 1'b0;
        idle_inputs();
        @(posedge clk_i); #1;
        arst_i = 1'b1;
        last_m = 1; held = -1; busy = 1'b0; owner = 0; rd_wait = 0; rd_addr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk_i); #1;
            s_rvalid_i = 1'b0;
            if (busy) begin
                if (rd_wait == 0) begin
                    s_rvalid_i = 1'b1;
                    s_rdata_i  = hash(rd_addr);
                end else begin
                    rd_wait--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                s_rvalid_i = 1'b1;
                s_rdata_i  = $urandom;
            end
            for (int m = 0; m < 2; m++) begin
                if (!av[m] && $urandom_range(0, 2) != 0) begin
                    av[m] = 1'b1;
                    ad[m] = $urandom & 32'hFFFF_FFFC;
                    wd[m] = $urandom;
                    st[m] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                end
            end
            drive_masters();
            s_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            // The slave sees the held request if one is stalled, else alternate among requesters
            win = -1;
            if (!busy) begin
                if (held >= 0) win = held;
                else if (av[0] && av[1]) win = 1 - last_m;
                else if (av[0]) win = 0;
                else if (av[1]) win = 1;
            end
            chk("r s_avalid", 32'(s_avalid_o), 32'(win >= 0));
            chk("r m0_ready", 32'(m0_ready_o), 32'(win == 0 && s_ready_i));
            chk("r m1_ready", 32'(m1_ready_o), 32'(win == 1 && s_ready_i));
            chk("r m0_rvalid", 32'(m0_rvalid_o), 32'(busy && s_rvalid_i && owner == 0));
            chk("r m1_rvalid", 32'(m1_rvalid_o), 32'(busy && s_rvalid_i && owner == 1));
            if (win >= 0) begin
                chk("r s_addr", s_addr_o, ad[win]);
                chk("r s_wdata", s_wdata_o, wd[win]);
                chk("r s_wstrb", 32'(s_wstrb_o), 32'(st[win]));
            end
            if (busy && s_rvalid_i) begin
                chk("r rdata", (owner == 0) ? m0_rdata_o : m1_rdata_o, hash(rd_addr));
                busy = 1'b0;
            end
            if (win >= 0) begin
                if (s_ready_i) begin
                    last_m = win;
                    held   = -1;
                    if (st[win] == 4'h0) begin
                        busy    = 1'b1;
                        owner   = win;
                        rd_wait = $urandom_range(0, 3);
                        rd_addr = ad[win];
                    end
                    av[win] = 1'b0;
                end else begin
                    held = win;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
